// File: rtl/matriz_loader.sv
// Serial 8-bit element loader that packs two square operand matrices into buses.
// Optional LOADER_TRANSPOSE_B_EN: pack B transposed (B(r,c) -> slot (c,r)).
module matriz_loader #(
    parameter int unsigned ELEM_W  = 8,
    parameter int unsigned MAX_DIM = 5,
    parameter int unsigned BUS_W   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        size,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BUS_W-1:0]  matriz_a,
    output logic [BUS_W-1:0]  matriz_b,
    output logic [2:0]        size_out,
    output logic              out_valid,
    input  logic              out_ack,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IDX_W = $clog2(BUS_W);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       row_q, row_d;
    logic [2:0]       col_q, col_d;
    logic [2:0]       size_q, size_d;
    logic [BUS_W-1:0] a_q, a_d;
    logic [BUS_W-1:0] b_q, b_d;
    logic             err_q, err_d;

    logic             xfer;
    logic             size_ok;
    logic             last_col;
    logic             last_row;
    logic [IDX_W-1:0] off_a;
    logic [IDX_W-1:0] off_b;

    assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign xfer     = in_valid && in_ready;
    assign size_ok  = (size >= 3'd2) && (size <= 3'd5);
    assign last_col = (col_q == size_q - 3'd1);
    assign last_row = (row_q == size_q - 3'd1);

    // Fixed MAX_DIM stride regardless of the loaded size
    assign off_a = IDX_W'((32'(row_q) * MAX_DIM + 32'(col_q)) * ELEM_W);
`ifdef LOADER_TRANSPOSE_B_EN
    assign off_b = IDX_W'((32'(col_q) * MAX_DIM + 32'(row_q)) * ELEM_W);
`else
    assign off_b = off_a;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        size_d  = size_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_ok) begin
                        state_d = LOAD_A;
                        size_d  = size;
                        a_d     = '0;
                        b_d     = '0;
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD_A, LOAD_B: begin
                if (xfer) begin
                    if (state_q == LOAD_A) a_d[off_a +: ELEM_W] = in_data;
                    else                   b_d[off_b +: ELEM_W] = in_data;
                    if (last_col) begin
                        col_d = 3'd0;
                        if (last_row) begin
                            row_d   = 3'd0;
                            state_d = (state_q == LOAD_A) ? LOAD_B : DONE;
                        end else begin
                            row_d = row_q + 3'd1;
                        end
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end
            DONE: begin
                if (out_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            size_q  <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            size_q  <= size_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
        end
    end

    assign matriz_a  = a_q;
    assign matriz_b  = b_q;
    assign size_out  = size_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_matriz_loader.sv
// Directed bench for matriz_loader: 2x2, 5x5 stalled, invalid sizes, mid-op events.
// Build with LOADER_TRANSPOSE_B_EN to expect B packed transposed.
module tb_matriz_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   size;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] matriz_a;
    logic [255:0] matriz_b;
    logic [2:0]   size_out;
    logic         out_valid;
    logic         out_ack;
    logic         busy;
    logic         err;

    int nvec = 0;
    int nerr = 0;
    int nxfer = 0;

    matriz_loader dut (
        .clk(clk), .rst(rst), .start(start), .size(size),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .matriz_a(matriz_a), .matriz_b(matriz_b), .size_out(size_out),
        .out_valid(out_valid), .out_ack(out_ack), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst && in_valid && in_ready) nxfer++;

`ifdef LOADER_TRANSPOSE_B_EN
    localparam bit TR = 1'b1;
    localparam logic [255:0] B2 = 256'h08060000000705;
`else
    localparam bit TR = 1'b0;
    localparam logic [255:0] B2 = 256'h08070000000605;
`endif
    localparam logic [255:0] A2 = 256'h04030000000201;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int w = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) chk("rdy_timeout", 256'(in_ready), 256'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic go(input logic [2:0] s);
        start = 1'b1;
        size  = s;
        tick();
        start = 1'b0;
    endtask

    // Expected bus: element k = base + step*k, row-major, 5-wide stride
    function automatic logic [255:0] pk(input int n, input int base,
                                        input int step, input bit tr);
        logic [255:0] v = '0;
        for (int k = 0; k < n * n; k++) begin
            int r = k / n;
            int c = k % n;
            int s = tr ? (c * 5 + r) : (r * 5 + c);
            v[s*8 +: 8] = 8'(base + step * k);
        end
        return v;
    endfunction

    task automatic load2();
        go(3'd2);
        for (int k = 1; k <= 4; k++) send(8'(k));
        for (int k = 5; k <= 7; k++) send(8'(k));
        chk("ov_pre", 256'(out_valid), 256'd0);
        send(8'd8);
    endtask

    initial begin
        int x0;
        logic [255:0] v;
        rst = 1'b0; start = 1'b0; size = 3'd0;
        in_data = 8'd0; in_valid = 1'b0; out_ack = 1'b0;
        tick();
        tick();
        chk("rst_a", matriz_a, 256'd0);
        chk("rst_b", matriz_b, 256'd0);
        v = {247'd0, size_out, out_valid, err, busy, in_ready, 2'b0};
        chk("rst_ctl", v, 256'd0);
        rst = 1'b1;
        tick();

        load2();
        chk("2_ov", 256'(out_valid), 256'd1);
        chk("2_a", matriz_a, A2);
        chk("2_b", matriz_b, B2);
        chk("2_size", 256'(size_out), 256'd2);
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        chk("2_ack", {254'd0, out_valid, busy}, 256'd0);
        chk("2_keep", matriz_a, A2);

        x0 = nxfer;
        go(3'd5);
        for (int k = 0; k < 25; k++) begin
            send(8'(k + 1));
            tick();
        end
        for (int k = 0; k < 25; k++) begin
            send(8'(8'hFF - k));
            tick();
        end
        chk("5_xfers", 256'(nxfer - x0), 256'd50);
        chk("5_ov", 256'(out_valid), 256'd1);
        chk("5_a199", 256'(matriz_a[199:192]), 256'd25);
        chk("5_b7", 256'(matriz_b[7:0]), 256'hFF);
        chk("5_hi", {matriz_a[255:200], matriz_b[255:200]}, 256'd0);
        chk("5_a", matriz_a, pk(5, 1, 1, 1'b0));
        chk("5_b", matriz_b, pk(5, 255, -1, TR));
        go(3'd3);
        chk("done_start", {253'd0, size_out}, 256'd5);
        chk("done_ov", 256'(out_valid), 256'd1);
        start = 1'b1; size = 3'd2; out_ack = 1'b1;
        tick();
        start = 1'b0; out_ack = 1'b0;
        chk("ack_start", {251'd0, size_out, out_valid, busy}, 256'd20);

        go(3'd0);
        chk("inv0", {253'd0, err, busy, in_ready}, 256'd4);
        go(3'd7);
        chk("inv7", {253'd0, err, busy, in_ready}, 256'd4);
        chk("inv_bus", matriz_a, pk(5, 1, 1, 1'b0));
        go(3'd3);
        chk("val3", {253'd0, err, busy, in_ready}, 256'd3);

        for (int k = 0; k < 9; k++) send(8'(k + 10));
        for (int k = 0; k < 2; k++) send(8'(k + 40));
        go(3'd2);
        chk("lb_size", 256'(size_out), 256'd3);
        x0 = nxfer;
        for (int k = 2; k < 9; k++) send(8'(k + 40));
        chk("lb_xfers", 256'(nxfer - x0), 256'd7);
        chk("3_a", matriz_a, pk(3, 10, 1, 1'b0));
        chk("3_b", matriz_b, pk(3, 40, 1, TR));
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;

        go(3'd4);
        for (int k = 0; k < 3; k++) send(8'hAA);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mr_a", matriz_a, 256'd0);
        chk("mr_b", matriz_b, 256'd0);
        v = {247'd0, size_out, out_valid, err, busy, in_ready, 2'b0};
        chk("mr_ctl", v, 256'd0);
        load2();
        chk("mr2_a", matriz_a, A2);
        chk("mr2_b", matriz_b, B2);
        chk("mr2_ov", 256'(out_valid), 256'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
